cpu_run_monitor: RTL and testbench

Synthesizable run-control and performance monitor that sits beside the `cpu` core and observes its fetch stage and a configurable set of pipeline event strobes. It arms on a start pulse, counts cycles and per-channel events, and detects end-of-program when a halt instruction is fetched. After a fixed pipeline-drain window it freezes with a done flag; if no halt is seen before a cycle limit, it freezes with a timeout flag. Counters are read back through an indexed, registered read port, so bring-up and self-checking benches need no hierarchical probing.

---
 rtl/cpu_run_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor
// ---------------
// Run-control and performance monitor that sits beside the cpu core.
// A start pulse arms it. While armed it counts clock cycles and per-channel
// pipeline event strobes. It stops when the fetch stage presents the halt
// encoding, or when the cycle limit is reached first.
// After a halt, a fixed drain window lets in-flight events settle. The monitor
// then freezes with `done` set. On a timeout it freezes with `timeout` set.
// Counters are read through an indexed port with a one-cycle registered latency.
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   start    in   arm pulse (honoured only in IDLE/DONE/TIMED_OUT)
//   f_inst   in   instruction currently in fetch
//   f_pc     in   PC of f_inst
//   evt      in   event strobes, one counter per bit
//   rd_sel   in   0 = cycle counter, k = event counter k-1, > NUM_EVT reads 0
//   rd_data  out  registered value of the selected counter
//   running  out  high while in RUN or DRAIN
//   done     out  high in DONE
//   timeout  out  high in TIMED_OUT
//   halt_pc  out  f_pc captured when the halt instruction was fetched
module cpu_run_monitor #(
  parameter int               XLEN         = 32,
  parameter int               PC_BITS      = 5,
  parameter int               CNT_W        = 32,
  parameter int               NUM_EVT      = 4,
  parameter int               DRAIN_CYCLES = 5,
  parameter int               TIMEOUT      = 2000,
  parameter logic [XLEN-1:0]  HALT_INST    = {XLEN{1'b0}},
  parameter int               SEL_W        = $clog2(NUM_EVT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [XLEN-1:0]     f_inst,
  input  logic [PC_BITS-1:0]  f_pc,
  input  logic [NUM_EVT-1:0]  evt,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [CNT_W-1:0]    rd_data,
  output logic                running,
  output logic                done,
  output logic                timeout,
  output logic [PC_BITS-1:0]  halt_pc
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    DRAIN     = 3'd2,
    DONE      = 3'd3,
    TIMED_OUT = 3'd4
  } state_t;

  // Compare against the limit in a width wide enough for both operands.
  // A narrow counter that can never reach the limit then never times out,
  // because it saturates first. The limit is not truncated into a false match.
  localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [CMP_W-1:0] TIMEOUT_V = CMP_W'(TIMEOUT);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]    evt_cnt_q [NUM_EVT];
  logic [CNT_W-1:0]    evt_cnt_d [NUM_EVT];
  logic [DW-1:0]       drain_cnt_q, drain_cnt_d;
  logic [PC_BITS-1:0]  halt_pc_q, halt_pc_d;
  logic [CNT_W-1:0]    rd_data_q, rd_data_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                at_limit;
  logic                is_halt;

  // Saturating increment: an all-ones counter stays put instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign at_limit = (CMP_W'(cycle_cnt_q) == TIMEOUT_V);
  assign is_halt  = (f_inst == HALT_INST);

  // Next-state, counter update and read-port selection.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    evt_cnt_d   = evt_cnt_q;
    drain_cnt_d = drain_cnt_q;
    halt_pc_d   = halt_pc_q;

    case (state_q)
      IDLE, DONE, TIMED_OUT: begin
        if (start) begin
          state_d     = RUN;
          cycle_cnt_d = {CNT_W{1'b0}};
          for (int i = 0; i < NUM_EVT; i++) begin
            evt_cnt_d[i] = {CNT_W{1'b0}};
          end
          drain_cnt_d = {DW{1'b0}};
          halt_pc_d   = {PC_BITS{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        cycle_cnt_d = sat_inc(cycle_cnt_q);
        for (int i = 0; i < NUM_EVT; i++) begin
          if (evt[i]) begin
            evt_cnt_d[i] = sat_inc(evt_cnt_q[i]);
          end else begin
            evt_cnt_d[i] = evt_cnt_q[i];
          end
        end
        // Halt wins over timeout when both land on the same edge.
        if (is_halt) begin
          state_d     = DRAIN;
          halt_pc_d   = f_pc;
          drain_cnt_d = {DW{1'b0}};
        end else if (at_limit) begin
          state_d = TIMED_OUT;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        // The cycle count stays frozen at the halt edge, but events are still
        // counted, including on the final drain edge.
        for (int i = 0; i < NUM_EVT; i++) begin
          if (evt[i]) begin
            evt_cnt_d[i] = sat_inc(evt_cnt_q[i]);
          end else begin
            evt_cnt_d[i] = evt_cnt_q[i];
          end
        end
        drain_cnt_d = drain_cnt_q + {{(DW-1){1'b0}}, 1'b1};
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The read port sees pre-update counter values.
    rd_data_d = {CNT_W{1'b0}};
    if (rd_sel == {SEL_W{1'b0}}) begin
      rd_data_d = cycle_cnt_q;
    end else begin
      for (int k = 0; k < NUM_EVT; k++) begin
        if (int'(rd_sel) == k + 1) begin
          rd_data_d = evt_cnt_q[k];
        end else begin
          rd_data_d = rd_data_d;
        end
      end
    end

    running_d = (state_d == RUN) || (state_d == DRAIN);
    done_d    = (state_d == DONE);
    timeout_d = (state_d == TIMED_OUT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cycle_cnt_q <= {CNT_W{1'b0}};
      for (int i = 0; i < NUM_EVT; i++) begin
        evt_cnt_q[i] <= {CNT_W{1'b0}};
      end
      drain_cnt_q <= {DW{1'b0}};
      halt_pc_q   <= {PC_BITS{1'b0}};
      rd_data_q   <= {CNT_W{1'b0}};
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      for (int i = 0; i < NUM_EVT; i++) begin
        evt_cnt_q[i] <= evt_cnt_d[i];
      end
      drain_cnt_q <= drain_cnt_d;
      halt_pc_q   <= halt_pc_d;
      rd_data_q   <= rd_data_d;
      running_q   <= running_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign rd_data = rd_data_q;
  assign running = running_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign halt_pc = halt_pc_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor.
// Instance A uses the default parameters: halt/drain, timeout, halt on the
// timeout edge, and mid-run reset.
// Instance B uses CNT_W=4 and TIMEOUT=20: saturation, ignored start pulses,
// restart from DONE, and an out-of-range read select.
module tb_cpu_run_monitor;

  localparam logic [31:0] NOP = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start_a, start_b;
  logic [31:0] inst_a, inst_b;
  logic [4:0]  pc_a, pc_b;
  logic [3:0]  evt_a, evt_b;
  logic [2:0]  sel_a, sel_b;
  logic [31:0] rd_a;
  logic [3:0]  rd_b;
  logic        run_a, done_a, to_a, run_b, done_b, to_b;
  logic [4:0]  hpc_a, hpc_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_run_monitor dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .f_inst(inst_a), .f_pc(pc_a),
    .evt(evt_a), .rd_sel(sel_a), .rd_data(rd_a), .running(run_a),
    .done(done_a), .timeout(to_a), .halt_pc(hpc_a)
  );

  cpu_run_monitor #(.CNT_W(4), .TIMEOUT(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .f_inst(inst_b), .f_pc(pc_b),
    .evt(evt_b), .rd_sel(sel_b), .rd_data(rd_b), .running(run_b),
    .done(done_b), .timeout(to_b), .halt_pc(hpc_b)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    inst_a = NOP; inst_b = NOP; pc_a = 5'd0; pc_b = 5'd0;
    evt_a = 4'b0000; evt_b = 4'b0000; sel_a = 3'd0; sel_b = 3'd0;
    #12;
    n_tests++;
    if ({run_a, done_a, to_a, hpc_a, rd_a} !== 40'd0) begin
      n_fail++; $display("FAIL reset_a: got %h expected 0", {run_a, done_a, to_a, hpc_a, rd_a});
    end
    n_tests++;
    if ({run_b, done_b, to_b, hpc_b, rd_b} !== 12'd0) begin
      n_fail++; $display("FAIL reset_b: got %h expected 0", {run_b, done_b, to_b, hpc_b, rd_b});
    end
    rst_n = 1'b1;
    evt_a = 4'b0001;
    tick(3);
    n_tests++;
    if ({run_a, rd_a} !== 33'd0) begin
      n_fail++; $display("FAIL idle_no_count: got run=%0b rd=%0d expected 0/0", run_a, rd_a);
    end
  endtask

  task automatic test_halt_drain;
    evt_a = 4'b0001; inst_a = NOP;
    start_a = 1'b1; tick(1); start_a = 1'b0;      // edge 0
    n_tests++;
    if (run_a !== 1'b1) begin
      n_fail++; $display("FAIL run_after_start: got %0b expected 1", run_a);
    end
    tick(9);                                       // counted edges 1..9
    inst_a = 32'h0; pc_a = 5'd9; tick(1);          // halt on edge 10
    inst_a = NOP; pc_a = 5'd3;
    n_tests++;
    if (run_a !== 1'b1 || hpc_a !== 5'd9) begin
      n_fail++; $display("FAIL drain_entry: got run=%0b halt_pc=%0d expected 1/9", run_a, hpc_a);
    end
    tick(4);
    n_tests++;
    if (done_a !== 1'b0) begin
      n_fail++; $display("FAIL done_early: got %0b expected 0", done_a);
    end
    tick(1);
    n_tests++;
    if (done_a !== 1'b1 || run_a !== 1'b0 || to_a !== 1'b0) begin
      n_fail++; $display("FAIL done_at_h5: got done=%0b run=%0b to=%0b expected 1/0/0", done_a, run_a, to_a);
    end
    sel_a = 3'd0; tick(1);
    n_tests++;
    if (rd_a !== 32'd10) begin
      n_fail++; $display("FAIL halt_cycle_cnt: got %0d expected 10", rd_a);
    end
    sel_a = 3'd1; tick(1);
    n_tests++;
    if (rd_a !== 32'd15) begin
      n_fail++; $display("FAIL halt_evt0_cnt: got %0d expected 15", rd_a);
    end
    sel_a = 3'd2; tick(1);
    n_tests++;
    if (rd_a !== 32'd0) begin
      n_fail++; $display("FAIL halt_evt1_cnt: got %0d expected 0", rd_a);
    end
  endtask

  task automatic test_timeout;
    evt_a = 4'b0001; inst_a = NOP;
    start_a = 1'b1; tick(1); start_a = 1'b0;
    n_tests++;
    if (hpc_a !== 5'd0) begin
      n_fail++; $display("FAIL start_clears_halt_pc: got %0d expected 0", hpc_a);
    end
    tick(2000);
    n_tests++;
    if (to_a !== 1'b0 || run_a !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early: got to=%0b run=%0b expected 0/1", to_a, run_a);
    end
    tick(1);                                       // counted edge 2001
    n_tests++;
    if (to_a !== 1'b1 || done_a !== 1'b0 || run_a !== 1'b0) begin
      n_fail++; $display("FAIL timeout_flag: got to=%0b done=%0b run=%0b expected 1/0/0", to_a, done_a, run_a);
    end
    tick(100);
    sel_a = 3'd0; tick(1);
    n_tests++;
    if (rd_a !== 32'd2001) begin
      n_fail++; $display("FAIL timeout_cycle_cnt: got %0d expected 2001", rd_a);
    end
    sel_a = 3'd1; tick(1);
    n_tests++;
    if (rd_a !== 32'd2001) begin
      n_fail++; $display("FAIL timeout_evt_frozen: got %0d expected 2001", rd_a);
    end
  endtask

  task automatic test_halt_on_timeout_edge;
    evt_a = 4'b0000; inst_a = NOP;
    start_a = 1'b1; tick(1); start_a = 1'b0;
    tick(2000);
    inst_a = 32'h0; pc_a = 5'd17; tick(1);         // counted edge 2001
    inst_a = NOP; pc_a = 5'd0;
    n_tests++;
    if (run_a !== 1'b1 || to_a !== 1'b0) begin
      n_fail++; $display("FAIL same_edge_drain: got run=%0b to=%0b expected 1/0", run_a, to_a);
    end
    tick(5);
    n_tests++;
    if (done_a !== 1'b1 || to_a !== 1'b0) begin
      n_fail++; $display("FAIL same_edge_done: got done=%0b to=%0b expected 1/0", done_a, to_a);
    end
    sel_a = 3'd0; tick(1);
    n_tests++;
    if (rd_a !== 32'd2001 || hpc_a !== 5'd17) begin
      n_fail++; $display("FAIL same_edge_counts: got cyc=%0d pc=%0d expected 2001/17", rd_a, hpc_a);
    end
  endtask

  task automatic test_saturation;
    evt_b = 4'b0010; inst_b = NOP; sel_b = 3'd2;
    start_b = 1'b1; tick(1); start_b = 1'b0;
    tick(4);
    start_b = 1'b1; tick(1); start_b = 1'b0;      // ignored in RUN (edge 5)
    tick(12);                                      // 17 counted edges
    tick(1);
    n_tests++;
    if (rd_b !== 4'd15 || run_b !== 1'b1) begin
      n_fail++; $display("FAIL sat_reach: got rd=%0d run=%0b expected 15/1", rd_b, run_b);
    end
    tick(3);
    n_tests++;
    if (rd_b !== 4'd15) begin
      n_fail++; $display("FAIL sat_hold: got %0d expected 15", rd_b);
    end
    inst_b = 32'h0; tick(1);                       // halt
    inst_b = NOP;
    start_b = 1'b1; tick(1); start_b = 1'b0;      // ignored in DRAIN
    sel_b = 3'd7; tick(3);
    n_tests++;
    if (done_b !== 1'b0 || rd_b !== 4'd0) begin
      n_fail++; $display("FAIL drain_start_sel7: got done=%0b rd=%0d expected 0/0", done_b, rd_b);
    end
    tick(1);
    n_tests++;
    if (done_b !== 1'b1) begin
      n_fail++; $display("FAIL sat_done: got %0b expected 1", done_b);
    end
    sel_b = 3'd2; tick(1);
    n_tests++;
    if (rd_b !== 4'd15) begin
      n_fail++; $display("FAIL sat_evt_after_start_pulses: got %0d expected 15", rd_b);
    end
    sel_b = 3'd0; tick(1);
    n_tests++;
    if (rd_b !== 4'd15) begin
      n_fail++; $display("FAIL sat_cycle: got %0d expected 15", rd_b);
    end
    evt_b = 4'b0000;
    start_b = 1'b1; tick(1); start_b = 1'b0;      // restart from DONE
    tick(1);
    n_tests++;
    if (rd_b !== 4'd0 || run_b !== 1'b1 || done_b !== 1'b0) begin
      n_fail++; $display("FAIL restart_cycle: got rd=%0d run=%0b done=%0b expected 0/1/0", rd_b, run_b, done_b);
    end
    sel_b = 3'd2; tick(1);
    n_tests++;
    if (rd_b !== 4'd0) begin
      n_fail++; $display("FAIL restart_evt: got %0d expected 0", rd_b);
    end
  endtask

  task automatic test_midrun_reset;
    evt_a = 4'b0001; inst_a = NOP; sel_a = 3'd0;
    start_a = 1'b1; tick(1); start_a = 1'b0;
    tick(37);                                      // cycle_cnt now 37
    n_tests++;
    if (rd_a !== 32'd36) begin
      n_fail++; $display("FAIL pre_reset_read: got %0d expected 36", rd_a);
    end
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    n_tests++;
    if ({run_a, done_a, to_a, hpc_a, rd_a} !== 40'd0 || run_b !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset: got %h run_b=%0b expected 0", {run_a, done_a, to_a, hpc_a, rd_a}, run_b);
    end
    tick(5);
    n_tests++;
    if (run_a !== 1'b0 || rd_a !== 32'd0) begin
      n_fail++; $display("FAIL post_reset_cycle: got run=%0b rd=%0d expected 0/0", run_a, rd_a);
    end
    sel_a = 3'd1; tick(1);
    n_tests++;
    if (rd_a !== 32'd0) begin
      n_fail++; $display("FAIL post_reset_evt: got %0d expected 0", rd_a);
    end
  endtask

  initial begin
    test_reset();
    test_halt_drain();
    test_timeout();
    test_halt_on_timeout_edge();
    test_saturation();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
